// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write arbiter.
// FIFO_ARB_STATS_EN (defined by the build) enables the beat/stall statistics counters.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or above start, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned pos;
  logic        found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    any   = |req;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one sync_fifo write port between NREQ producers.
// Build with FIFO_ARB_STATS_EN defined to add the stat_beats / stat_stalls outputs.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DW-1:0]     req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DW-1:0]          fifo_din,
  output logic [id_w(NREQ)-1:0]  grant_id,
  output logic                   busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]      stat_beats,
  output logic [STAT_W-1:0]      stat_stalls
`endif
);

  localparam int ID_W  = id_w(NREQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e        state;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;

  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [ID_W-1:0]   owner_nxt;
  logic [DW-1:0]     owner_data;
  logic              owner_valid;
  logic              accept;

  rr_pick #(
    .N  (NREQ),
    .IW (ID_W)
  ) u_pick (
    .req   (req_valid),
    .start (rr_ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign owner_valid = req_valid[owner];
  assign owner_data  = req_data[int'(owner)*DW +: DW];
  assign owner_nxt   = (int'(owner) == NREQ - 1) ? '0 : owner + ID_W'(1);

  // Handshake is combinational so fifo_full gates the write in the same cycle.
  always_comb begin
    accept     = 1'b0;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (state == BURST) begin
      accept           = owner_valid & ~fifo_full;
      fifo_wr_en       = accept;
      req_ready[owner] = accept;
      if (accept) fifo_din = owner_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner    <= pick_idx;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
              state  <= IDLE;
              rr_ptr <= owner_nxt;
            end
          end else if (!owner_valid) begin
            state  <= IDLE;
            rr_ptr <= owner_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_id = owner;
  assign busy     = (state == BURST);

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (accept && (stat_beats != '1)) stat_beats <= stat_beats + STAT_W'(1);
      if ((state == BURST) && owner_valid && fifo_full && (stat_stalls != '1))
        stat_stalls <= stat_stalls + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with queue-driven producers and a 16-deep FIFO model.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_beats;
  logic [15:0] stat_stalls;
`endif

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_beats (stat_beats),
    .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  src_q [4][$];
  logic [15:0] exp_q [$];
  logic [7:0]  fifo_mem [$];
  logic [7:0]  pop_q [$];
  int          wr_cyc [$];
  int          wr_cnt = 0;
  int          cyc = 0;
  int          fifo_cnt = 0;
  logic        sb_en = 1'b1;
  logic        force_full = 1'b0;
  logic        fifo_mode = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  rdy_snap = '0;
  logic        wr_snap = 1'b0;
  logic [7:0]  din_snap = '0;
  logic        rd_snap = 1'b0;

  assign fifo_full = force_full | (fifo_mode & (fifo_cnt == 16));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  initial forever begin
    @(negedge clk);
    rdy_snap = req_ready;
    wr_snap  = fifo_wr_en;
    din_snap = fifo_din;
    rd_snap  = rd_en;
    if (!reset) begin
      if (fifo_wr_en) begin
        chk("no_overflow", {31'd0, fifo_full}, 32'd0);
        chk("ready_owner", {28'd0, req_ready}, 32'(4'b0001 << grant_id));
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_write: got unexpected write %0h from %0d", fifo_din, grant_id);
          end else begin
            chk("sb_write", {16'd0, 6'd0, grant_id, fifo_din}, {16'd0, exp_q.pop_front()});
          end
        end
        wr_cnt++;
        wr_cyc.push_back(cyc);
      end else begin
        chk("idle_ready", {28'd0, req_ready}, 32'd0);
        chk("idle_din", {24'd0, fifo_din}, 32'd0);
      end
    end
  end

  // Producers and FIFO model: update just after the rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (fifo_mode) begin
      if (wr_snap) fifo_mem.push_back(din_snap);
      if (rd_snap && fifo_mem.size() != 0) pop_q.push_back(fifo_mem.pop_front());
    end
    fifo_cnt = fifo_mem.size();
    for (int i = 0; i < 4; i++) begin
      if (rdy_snap[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      req_valid[i]        = (src_q[i].size() != 0);
      req_data[i*8 +: 8]  = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
    end
  end

  task automatic reset_dut();
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q.delete();
    fifo_mem.delete();
    pop_q.delete();
    fifo_cnt   = 0;
    force_full = 1'b0;
    fifo_mode  = 1'b0;
    rd_en      = 1'b0;
    #20;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_cyc.delete();
  endtask

  task automatic wait_sb_empty(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 32'd0);
  endtask

  task automatic push_item(input int id, input logic [7:0] d);
    src_q[id].push_back(d);
    exp_q.push_back({6'd0, 2'(id), d});
  endtask

  initial begin : stim
    int base;
    int n;
    logic [7:0] exp_pop [$];

    // 1: reset in the middle of requester 1's burst
    sb_en = 1'b0;
    reset_dut();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 20; k++) src_q[i].push_back(8'(8'h40 * i + k + 1));
    n = 0;
    while (!(busy && grant_id == 2'd1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t1_reach_owner1", {31'd0, busy && grant_id == 2'd1}, 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t1_rst_ready", {28'd0, req_ready}, 32'd0);
    chk("t1_rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("t1_rst_din", {24'd0, fifo_din}, 32'd0);
    chk("t1_rst_grant", {30'd0, grant_id}, 32'd0);
    chk("t1_rst_busy", {31'd0, busy}, 32'd0);
    #19;
    reset = 1'b0;
    @(negedge clk);
    chk("t1_post_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("t1_post_busy", {31'd0, busy}, 32'd1);
    chk("t1_first_grant", {30'd0, grant_id}, 32'd0);

    // 2: single requester, then rotation pointer lands on 2
    reset_dut();
    sb_en = 1'b1;
    base = wr_cnt;
    push_item(1, 8'hA1);
    push_item(1, 8'hA2);
    push_item(1, 8'hA3);
    n = 0;
    while (!req_valid[1] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t2_busy_latency", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    chk("t2_grant", {30'd0, grant_id}, 32'd1);
    wait_sb_empty("t2_drain", 20);
    repeat (3) @(negedge clk);
    chk("t2_beats", wr_cnt - base, 32'd3);
    chk("t2_idle", {31'd0, busy}, 32'd0);
    push_item(2, 8'h25);
    push_item(0, 8'h05);
    wait_sb_empty("t2_rr_ptr", 20);

    // 3: fairness with everyone continuously valid
    reset_dut();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 4; k++) push_item(i, 8'(i * 16 + r * 4 + k));
    wait_sb_empty("t3_drain", 200);
    repeat (3) @(negedge clk);
    chk("t3_count", wr_cyc.size(), 32'd32);
    for (int k = 1; k < 32 && k < wr_cyc.size(); k++)
      chk($sformatf("t3_gap%0d", k), wr_cyc[k] - wr_cyc[k-1], (k % 4 == 0) ? 32'd2 : 32'd1);

    // 4: full stall after the second beat
    reset_dut();
    base = wr_cnt;
    for (int k = 0; k < 4; k++) push_item(2, 8'(8'hC0 + k));
    n = 0;
    while (!(fifo_wr_en && fifo_din == 8'hC1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_beat2_seen", {31'd0, fifo_wr_en && fifo_din == 8'hC1}, 32'd1);
    @(posedge clk);
    #1;
    force_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("t4_stall_wr_en", {31'd0, fifo_wr_en}, 32'd0);
      chk("t4_stall_ready", {28'd0, req_ready}, 32'd0);
      chk("t4_stall_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge clk);
    #1;
    force_full = 1'b0;
    wait_sb_empty("t4_drain", 20);
    repeat (4) @(negedge clk);
    chk("t4_beats", wr_cnt - base, 32'd4);
`ifdef FIFO_ARB_STATS_EN
    chk("t4_stat_beats", {16'd0, stat_beats}, 32'd4);
    chk("t4_stat_stalls", {16'd0, stat_stalls}, 32'd3);
`endif

    // 5: real backpressure from a 16-deep FIFO model
    reset_dut();
    fifo_mode = 1'b1;
    base = wr_cnt;
    for (int k = 0; k < 16; k++) begin
      push_item(0, 8'(8'hFF - k));
      exp_pop.push_back(8'(8'hFF - k));
    end
    push_item(0, 8'h11);
    exp_pop.push_back(8'h11);
    n = 0;
    while (fifo_cnt != 16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("t5_written16", wr_cnt - base, 32'd16);
    chk("t5_full", {31'd0, fifo_full}, 32'd1);
    chk("t5_held_valid", {31'd0, req_valid[0]}, 32'd1);
    chk("t5_held_ready", {28'd0, req_ready}, 32'd0);
    chk("t5_pending", exp_q.size(), 32'd1);
    @(posedge clk);
    #1;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wait_sb_empty("t5_last_beat", 20);
    repeat (2) @(negedge clk);
    chk("t5_written17", wr_cnt - base, 32'd17);
    @(posedge clk);
    #1;
    rd_en = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_pop_count", pop_q.size(), 32'd17);
    for (int k = 0; k < 17 && k < pop_q.size(); k++)
      chk($sformatf("t5_dout%0d", k), {24'd0, pop_q[k]}, {24'd0, exp_pop[k]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one sync_fifo write port (wr_en/din/full) between NREQ producers.
- Each producer uses a valid/ready handshake.
- The winning producer holds the FIFO for a bounded burst, then ownership rotates.
- Sits directly in front of sync_fifo, in the same clk domain; the read side is untouched.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width; matches sync_fifo din
MAX_BURST, 4, max beats per grant before forced rotation (1..16)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester data valid
req_data  input  NREQ*DW  packed data; requester i at bits [i*DW +: DW]
req_ready  output  NREQ  per-requester accept; one-hot or zero
fifo_full  input  1  sync_fifo full flag
fifo_wr_en  output  1  sync_fifo write enable
fifo_din  output  DW  sync_fifo write data
grant_id  output  clog2(NREQ)  current owner index
busy  output  1  high while in BURST

Behaviour:
- Reset (async, active-high):
  - state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
  - req_ready=0, fifo_wr_en=0, fifo_din=0, grant_id=0, busy=0.
  - Outputs drop immediately on reset assertion, including mid-burst; an in-flight beat is lost.
- State IDLE:
  - No writes.
  - If any req_valid: select the first set bit searching upward from rr_ptr with wrap. Register owner, clear beat_cnt, go to BURST.
  - Arbitration latency is 1 cycle.
- State BURST:
  - accept = req_valid[owner] & ~fifo_full.
  - Combinationally: fifo_wr_en = accept, req_ready[owner] = accept, fifo_din = owner's data when accept, else 0.
- Beat accounting:
  - On accept, beat_cnt increments.
  - fifo_full stalls the burst without ending it or counting.
- BURST -> IDLE when either:
  - an accepted beat brings the count to MAX_BURST, or
  - req_valid[owner]=0 for a cycle.
- On leaving BURST: rr_ptr = (owner+1) mod NREQ. There is one idle bubble between bursts.
- Producer rule: hold data stable while valid & ~ready. Dropping valid ends the burst with no penalty.
- Non-owners always see req_ready=0. Requests arriving during BURST wait for the next IDLE.
- Invariant: fifo_wr_en is never high while fifo_full is high, so no overflow is possible.
- grant_id reflects the registered owner; busy = (state==BURST).

Optional Feature:
FIFO_ARB_STATS_EN
- Defined: adds outputs stat_beats[15:0] and stat_stalls[15:0].
  - stat_beats counts accepted beats.
  - stat_stalls counts BURST cycles with req_valid[owner] & fifo_full.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, BURST}
  - ID_W = clog2(NREQ) helper
  - stats width constant (16)
- One sub-module rr_pick: combinational priority picker (req vector, start pointer -> grant index, any). This is the only logic reused elsewhere.

Test Plan:
1. Reset:
   - Pulse reset for 20 ns with all 4 req_valid high mid-burst.
   - All outputs read 0 during reset.
   - First grant after release goes to requester 0.
2. Single requester:
   - Requester 1 presents 0xA1,0xA2,0xA3, then drops valid.
   - grant_id=1 one cycle after valid.
   - Exactly 3 fifo_wr_en pulses with those values; then IDLE and rr_ptr=2.
3. Fairness:
   - All 4 requesters continuously valid, MAX_BURST=4.
   - Grants go 0,1,2,3,0; each burst is 4 consecutive beats, separated by 1 idle cycle.
4. Full stall:
   - fifo_full high for 3 cycles after beat 2 of a burst.
   - fifo_wr_en=0 and req_ready=0 for those cycles.
   - Burst resumes; total of 4 beats with no duplicates.
5. Integration with sync_fifo (16 deep):
   - Requester 0 offers 17 beats: 0xFF..0xF0, then 0x11.
   - 16 beats are written; 0x11 is held until one rd_en pop.
   - dout order matches the write order and fifo_wr_en never coincides with full.
6. Stats (FIFO_ARB_STATS_EN defined): scenario 4 ends with stat_beats=4 and stat_stalls=3.
